// File: rtl/fft_64.sv
// fft_64 -- 64-point radix-2 decimation-in-time FFT core for the audio visualizer.
//
// Takes 64 real signed time samples and produces 64 bin values. The core is
// iterative: one complex butterfly per clock, 6 stages x 32 butterflies
// (192 compute cycles). It uses fixed latency and does no per-stage scaling.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous, active-high reset (aborts a running transform)
//   start         transform request, sampled only in IDLE
//   done          one-cycle pulse: freq_samples were just updated
//   time_samples  [0:63] signed two's complement samples, index = time order
//   freq_samples  [0:63] bin values, index = bin number
//
// Build option (macro FFT_64_MAG_EN):
//   defined   -> freq_samples[k] = unsigned min((|Re X|+|Im X|)>>6, 2^WIDTH-1)
//   undefined -> freq_samples[k] = signed sat(Re X >>> 6); imaginary part dropped
module fft_64 #(
  parameter int WIDTH    = 12,
  parameter int TW_WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             done,
  input  logic [WIDTH-1:0] time_samples [0:63],
  output logic [WIDTH-1:0] freq_samples [0:63]
);

  // Internal word: 6 bits of growth for 64 points plus one guard bit.
  localparam int IW = WIDTH + 7;
  // Width of a sum of two full-precision products.
  localparam int PW = IW + TW_WIDTH + 1;
  // Twiddles are scaled so that 1.0 = 2^(TW_WIDTH-2).
  localparam int SH = TW_WIDTH - 2;

  localparam logic signed [IW-1:0] SAT_MAX = IW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_MIN = IW'(-(2 ** (WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               state_r;
  logic [2:0]           stage_r;
  logic [4:0]           bfly_r;
  logic signed [IW-1:0] re_r [0:63];
  logic signed [IW-1:0] im_r [0:63];

  // Quarter-wave cosine table, round(cos(2*pi*i/64) * 1024) for i = 0..15.
  // Index 16 (cos 90 deg = 0) falls through to the default.
  function automatic logic signed [TW_WIDTH-1:0] quarter_cos(input logic [4:0] idx);
    logic signed [TW_WIDTH-1:0] val;
    case (idx)
      5'd0:    val = 12'sd1024;
      5'd1:    val = 12'sd1019;
      5'd2:    val = 12'sd1004;
      5'd3:    val = 12'sd980;
      5'd4:    val = 12'sd946;
      5'd5:    val = 12'sd903;
      5'd6:    val = 12'sd851;
      5'd7:    val = 12'sd792;
      5'd8:    val = 12'sd724;
      5'd9:    val = 12'sd650;
      5'd10:   val = 12'sd569;
      5'd11:   val = 12'sd483;
      5'd12:   val = 12'sd392;
      5'd13:   val = 12'sd297;
      5'd14:   val = 12'sd200;
      5'd15:   val = 12'sd100;
      default: val = 12'sd0;
    endcase
    return val;
  endfunction

  // Bit-reversal of a 6-bit address, used to reorder the input for DIT.
  function automatic logic [5:0] bit_rev6(input logic [5:0] v);
    return {v[0], v[1], v[2], v[3], v[4], v[5]};
  endfunction

  // Converts one accumulated bin (re, im) to the output format.
  function automatic logic [WIDTH-1:0] fmt_bin(input logic signed [IW-1:0] re,
                                               input logic signed [IW-1:0] im);
    logic [WIDTH-1:0] res;
`ifdef FFT_64_MAG_EN
    logic signed [IW:0] re_x;
    logic signed [IW:0] im_x;
    logic [IW:0]        abs_re;
    logic [IW:0]        abs_im;
    logic [IW:0]        mag;
    // Extend by one bit so negating the most negative word cannot overflow.
    re_x   = {re[IW-1], re};
    im_x   = {im[IW-1], im};
    abs_re = (re_x < 0) ? $unsigned(-re_x) : $unsigned(re_x);
    abs_im = (im_x < 0) ? $unsigned(-im_x) : $unsigned(im_x);
    mag    = (abs_re + abs_im) >> 6;
    if (mag > (IW + 1)'((2 ** WIDTH) - 1)) begin
      res = '1;
    end else begin
      res = mag[WIDTH-1:0];
    end
`else
    logic signed [IW-1:0] scaled;
    scaled = re >>> 6;
    if (scaled > SAT_MAX) begin
      res = SAT_MAX[WIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      res = SAT_MIN[WIDTH-1:0];
    end else begin
      res = scaled[WIDTH-1:0];
    end
    // Imaginary part is not used by the signed build.
    res = res | (WIDTH'(im) & {WIDTH{1'b0}});
`endif
    return res;
  endfunction

  logic [5:0]                 half_s;
  logic [5:0]                 mask_s;
  logic [5:0]                 pos_s;
  logic [5:0]                 top_s;
  logic [5:0]                 bot_s;
  logic [4:0]                 tw_idx_s;
  logic [4:0]                 lo_s;
  logic [4:0]                 hi_s;
  logic signed [TW_WIDTH-1:0] q_lo_s;
  logic signed [TW_WIDTH-1:0] q_hi_s;
  logic signed [TW_WIDTH-1:0] cos_s;
  logic signed [TW_WIDTH-1:0] sin_s;
  logic signed [IW-1:0]       ar_s;
  logic signed [IW-1:0]       ai_s;
  logic signed [IW-1:0]       br_s;
  logic signed [IW-1:0]       bi_s;
  logic signed [PW-1:0]       prod_re_s;
  logic signed [PW-1:0]       prod_im_s;
  logic signed [IW-1:0]       tr_s;
  logic signed [IW-1:0]       ti_s;

  // Butterfly address generation, twiddle lookup and the W*b product.
  always_comb begin
    // Butterfly b of stage s: the low s bits of b are the position inside the
    // group and the upper bits pick the group (the group stride is 2^(s+1)).
    half_s   = 6'd1 << stage_r;
    mask_s   = half_s - 6'd1;
    pos_s    = {1'b0, bfly_r} & mask_s;
    top_s    = (({1'b0, bfly_r} & ~mask_s) << 1) | pos_s;
    bot_s    = top_s | half_s;
    tw_idx_s = 5'(pos_s << (3'd5 - stage_r));

    // W = cos(t) - j*sin(t), with t = 2*pi*m/64. Angles past 90 degrees
    // reuse the quarter table: cos(90+x) = -sin(x), sin(90+x) = cos(x).
    lo_s   = {1'b0, tw_idx_s[3:0]};
    hi_s   = 5'd16 - lo_s;
    q_lo_s = quarter_cos(lo_s);
    q_hi_s = quarter_cos(hi_s);
    cos_s  = q_lo_s;
    sin_s  = q_hi_s;
    if (tw_idx_s[4]) begin
      cos_s = -q_hi_s;
      sin_s = q_lo_s;
    end else begin
      cos_s = q_lo_s;
      sin_s = q_hi_s;
    end

    ar_s = re_r[top_s];
    ai_s = im_r[top_s];
    br_s = re_r[bot_s];
    bi_s = im_r[bot_s];

    // (c - j*s)(br + j*bi) = (c*br + s*bi) + j(c*bi - s*br), floor-scaled back.
    prod_re_s = PW'(br_s) * PW'(cos_s) + PW'(bi_s) * PW'(sin_s);
    prod_im_s = PW'(bi_s) * PW'(cos_s) - PW'(br_s) * PW'(sin_s);
    tr_s      = IW'(prod_re_s >>> SH);
    ti_s      = IW'(prod_im_s >>> SH);
  end

  // Control FSM, working-RAM updates and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      stage_r <= 3'd0;
      bfly_r  <= 5'd0;
      done    <= 1'b0;
      for (int k = 0; k < 64; k++) begin
        re_r[k]         <= '0;
        im_r[k]         <= '0;
        freq_samples[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            for (int n = 0; n < 64; n++) begin
              re_r[bit_rev6(6'(n))] <= IW'($signed(time_samples[n]));
              im_r[bit_rev6(6'(n))] <= '0;
            end
            stage_r <= 3'd0;
            bfly_r  <= 5'd0;
            state_r <= COMPUTE;
          end else begin
            state_r <= IDLE;
          end
        end
        COMPUTE: begin
          re_r[top_s] <= ar_s + tr_s;
          im_r[top_s] <= ai_s + ti_s;
          re_r[bot_s] <= ar_s - tr_s;
          im_r[bot_s] <= ai_s - ti_s;
          if (bfly_r == 5'd31) begin
            bfly_r <= 5'd0;
            if (stage_r == 3'd5) begin
              stage_r <= 3'd0;
              state_r <= DONE;
            end else begin
              stage_r <= stage_r + 3'd1;
            end
          end else begin
            bfly_r <= bfly_r + 5'd1;
          end
        end
        DONE: begin
          // All bins are updated on the same edge, so the output is never partial.
          for (int k = 0; k < 64; k++) begin
            freq_samples[k] <= fmt_bin(re_r[k], im_r[k]);
          end
          done    <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_64.sv
// tb_fft_64 -- directed self-checking bench for fft_64.
// Covers reset state, impulse/DC/cosine/full-scale inputs, a random vector with
// start held high, ignored start during compute, and reset mid-transform.
module tb_fft_64;

  localparam int WIDTH = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             done;
  logic [WIDTH-1:0] time_samples [0:63];
  logic [WIDTH-1:0] freq_samples [0:63];

  int n_vec = 0;
  int n_err = 0;
  int exp_bins [0:63];
  int snap [0:63];
  int lat;
  int lat2;
  int cnt;
  int seen;
  real re_acc;
  real im_acc;
  real ang;

  int rand_vec [0:63] = '{
    -163,   35,  196, -128,   77,  -12,  150, -199,    4,   88,  -57,  120, -140,   63,    9,  -91,
     181,  -33,   45, -176,  112,    0,  -68,  139,   -5,  199, -110,   27,   58, -147,   93,  -21,
    -200,  166,  -74,   11,  130,  -96,   39, -187,   72,  154,  -49,   -3,  118, -132,   66,   21,
     -15,  101, -158,   84,  190,  -60, -121,   47,    8,  -83,  175,  -39,  143, -106,   52, -175};

  // round(1000*cos(2*pi*4*n/64)) repeats every 16 samples.
  int cos_vec [0:15] = '{1000, 924, 707, 383, 0, -383, -707, -924,
                         -1000, -924, -707, -383, 0, 383, 707, 924};

  always #5 clk = ~clk;

  fft_64 #(.WIDTH(12), .TW_WIDTH(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .done         (done),
    .time_samples (time_samples),
    .freq_samples (freq_samples)
  );

  function automatic int bin_val(input logic [WIDTH-1:0] v);
`ifdef FFT_64_MAG_EN
    return int'($unsigned(v));
`else
    return int'($signed(v));
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_bins(input string tag);
    for (int k = 0; k < 64; k++) begin
      int obs;
      int diff;
      bit in_tol;
      obs    = bin_val(freq_samples[k]);
      diff   = obs - exp_bins[k];
      in_tol = (diff <= 2) && (diff >= -2);
      n_vec++;
      assert (in_tol === 1'b1) else begin
        n_err++;
        $error("FAIL %s bin %0d observed=%0d expected=%0d (+/-2)", tag, k, obs, exp_bins[k]);
      end
    end
  endtask

  task automatic set_exp(input int v);
    for (int k = 0; k < 64; k++) exp_bins[k] = v;
  endtask

  // Launches one transform and waits for done; latency is counted in edges after the accept edge.
  task automatic run_fft(input string tag, input bit scramble, input bit poke);
    int l;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) begin
      for (int n = 0; n < 64; n++) time_samples[n] = WIDTH'(n * 37 + 5);
    end
    l = 0;
    while (done !== 1'b1 && l < 400) begin
      @(posedge clk);
      #1;
      l++;
      if (poke && l == 60) start = 1'b1;
      if (poke && l == 62) start = 1'b0;
    end
    check({tag, " latency"}, l, 193);
    check_bins(tag);
    @(posedge clk);
    #1;
    check({tag, " done width"}, int'(done), 0);
  endtask

  task automatic load_cos();
    for (int n = 0; n < 64; n++) time_samples[n] = WIDTH'(cos_vec[n % 16]);
    set_exp(0);
    exp_bins[4]  = 500;
    exp_bins[60] = 500;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int n = 0; n < 64; n++) time_samples[n] = '0;

    // Reset state.
    @(posedge clk); #1;
    check("done in reset 1", int'(done), 0);
    @(posedge clk); #1;
    check("done in reset 2", int'(done), 0);
    cnt = 0;
    for (int k = 0; k < 64; k++) if (freq_samples[k] !== '0) cnt++;
    check("reset freq nonzero count", cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Impulse; inputs scrambled after the accept edge must not matter.
    for (int n = 0; n < 64; n++) time_samples[n] = '0;
    time_samples[0] = 12'd2047;
    set_exp(31);
    run_fft("impulse", 1'b1, 1'b0);

    // DC level 100.
    for (int n = 0; n < 64; n++) time_samples[n] = 12'd100;
    set_exp(0);
    exp_bins[0] = 100;
    run_fft("dc", 1'b0, 1'b0);

    // Cosine at bin 4, with a stray start pulse during compute.
    load_cos();
    run_fft("cosine", 1'b0, 1'b1);

    // Full-scale negative DC: no internal overflow.
    for (int n = 0; n < 64; n++) time_samples[n] = 12'h800;
    set_exp(0);
`ifdef FFT_64_MAG_EN
    exp_bins[0] = 2048;
`else
    exp_bins[0] = -2048;
`endif
    run_fft("neg fullscale", 1'b0, 1'b0);

    // Random vector against a double-precision DFT, start held high.
    for (int n = 0; n < 64; n++) time_samples[n] = WIDTH'(rand_vec[n]);
    for (int k = 0; k < 64; k++) begin
      re_acc = 0.0;
      im_acc = 0.0;
      for (int n = 0; n < 64; n++) begin
        ang    = 2.0 * 3.14159265358979 * real'(k * n) / 64.0;
        re_acc = re_acc + real'(rand_vec[n]) * $cos(ang);
        im_acc = im_acc - real'(rand_vec[n]) * $sin(ang);
      end
`ifdef FFT_64_MAG_EN
      exp_bins[k] = $rtoi($floor(((re_acc < 0.0 ? -re_acc : re_acc) +
                                  (im_acc < 0.0 ? -im_acc : im_acc)) / 64.0));
`else
      exp_bins[k] = $rtoi($floor(re_acc / 64.0));
`endif
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (done !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check("random latency", lat, 193);
    check_bins("random");
    for (int k = 0; k < 64; k++) snap[k] = bin_val(freq_samples[k]);
    lat2 = 0;
    cnt  = 0;
    do begin
      @(posedge clk); #1;
      lat2++;
      if (lat2 == 100) begin
        for (int k = 0; k < 64; k++) if (bin_val(freq_samples[k]) !== snap[k]) cnt++;
        check("random hold mid-compute", cnt, 0);
      end
    end while (done !== 1'b1 && lat2 < 400);
    start = 1'b0;
    check("random done period", lat2, 194);
    cnt = 0;
    for (int k = 0; k < 64; k++) if (bin_val(freq_samples[k]) !== snap[k]) cnt++;
    check("random repeat identical", cnt, 0);
    @(posedge clk); #1;

    // Reset 50 cycles into compute aborts the transform.
    for (int n = 0; n < 64; n++) time_samples[n] = 12'd100;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("done in abort reset 1", int'(done), 0);
    @(posedge clk); #1;
    check("done in abort reset 2", int'(done), 0);
    cnt = 0;
    for (int k = 0; k < 64; k++) if (freq_samples[k] !== '0) cnt++;
    check("abort freq nonzero count", cnt, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (250) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1;
    end
    check("no done after abort", seen, 0);
    load_cos();
    run_fft("cosine after abort", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
